dcache_dm: RTL and testbench
============================

DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 8, giving the log2 of the number of one-word lines (256 lines).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port core_req, input, utils::mem_req_t: core request {valid, rw, addr (byte), data}.
REQ-005 SHALL have port core_res, output, utils::mem_res_t: response to the core {ready, data}.
REQ-006 SHALL have port mem_req, output, utils::mem_req_t: request to the memory controller (byte address).
REQ-007 SHALL have port mem_res, input, utils::mem_res_t: memory response {ready pulse, data}.
REQ-008 SHALL have port flush, input, 1 bit: invalidate all lines.
REQ-009 SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-010 SHALL have ports hit_count and miss_count, output, 32 bits each: statistics (see Configuration).

Function
REQ-011 SHALL be direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
REQ-012 SHALL decode addresses as: index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2]; addr[1:0] ignored.
REQ-013 SHALL hold tag and data arrays in block RAM with a 1-cycle read, and line-valid bits in a flop array.
REQ-014 SHALL implement FSM states IDLE, LOOKUP, MEM_WAIT and DONE.
REQ-015 IDLE: SHALL latch core_req and move to LOOKUP when core_req.valid=1 and flush=0.
REQ-016 IDLE: when flush=1, SHALL clear all valid bits in that cycle and stay in IDLE; flush has priority over a simultaneous core_req.valid, which is then taken on a later cycle.
REQ-017 LOOKUP read hit: SHALL set core_res.data to the line data, pulse core_res.ready and go to DONE; hit latency is 2 cycles from the sampled valid to ready high.
REQ-018 LOOKUP read miss: SHALL issue mem_req {valid=1, rw=0, addr=latched addr} and go to MEM_WAIT.
REQ-019 LOOKUP write: SHALL issue mem_req {valid=1, rw=1, addr, data} and go to MEM_WAIT.
REQ-020 LOOKUP write on a hit: SHALL also update the line data in the same cycle.
REQ-021 LOOKUP write on a miss: SHALL leave the arrays unchanged.
REQ-022 MEM_WAIT: on the edge where mem_res.ready=1, SHALL clear mem_req.valid, pulse core_res.ready and go to DONE.
REQ-023 MEM_WAIT on a read: SHALL also write the tag and mem_res.data into the line, set the line valid and return mem_res.data on core_res.data.
REQ-024 DONE: SHALL clear core_res.ready and return to IDLE, giving the core one cycle to drop valid.
REQ-025 SHALL make core_res.ready a one-cycle pulse per request, never held high for two consecutive cycles.
REQ-026 SHALL keep mem_req fields stable while mem_req.valid=1, and SHALL keep mem_req.valid low outside MEM_WAIT.
REQ-027 SHALL hold core_res.data stable until the next response.
REQ-028 SHALL ignore a flush asserted outside IDLE; it is not remembered.

Reset
REQ-029 On rst=1, SHALL set the state to IDLE, mem_req.valid=0, core_res.ready=0, clear all line-valid bits and zero hit_count/miss_count.
REQ-030 SHALL reset from any state, including MEM_WAIT with an outstanding memory request; that request is abandoned, and a mem_res.ready arriving after reset is ignored.
REQ-031 SHALL NOT reset core_res.data, mem_req.addr/data or the tag/data arrays.

Configuration
REQ-032 With macro DCACHE_STATS_EN defined, SHALL increment hit_count on each read hit and miss_count on each read miss in LOOKUP, wrapping modulo 2^32; writes count as neither.
REQ-033 Without DCACHE_STATS_EN, SHALL tie hit_count and miss_count to 0 and instantiate no counter flops.

Verification
REQ-034 Read miss: after reset, read 0x0000_0100 with memory returning 0xDEADBEEF -> one mem read to 0x100, core_res.data=0xDEADBEEF, one ready pulse.
REQ-035 Read hit: read 0x100 again -> no mem_req.valid, ready 2 cycles after valid sampled, data 0xDEADBEEF; miss_count=1, hit_count=1 with DCACHE_STATS_EN.
REQ-036 Write: write 0x12345678 to 0x100 (hit), then read 0x100 -> mem write seen with data 0x12345678; the read hits with no mem access and returns 0x12345678.
REQ-037 Conflict (INDEX_BITS=8): read 0x100, then read 0x500 (same index, different tag), then read 0x100 -> three memory reads in total.
REQ-038 Flush: flush=1 together with core_req.valid in IDLE, then read 0x100 -> valid bits cleared first, the read misses and mem read is issued.
REQ-039 Reset in MEM_WAIT: assert rst, then deliver mem_res.ready -> busy=0, no core_res.ready pulse, a subsequent read of the same address misses.

Source files
------------

// File: rtl/utils.sv
// utils: shared memory-bus request/response types.
//   mem_req_t : {valid, rw (1 = write), addr (byte address), data (write data)}
//   mem_res_t : {ready (one-cycle pulse), data (read data)}
package utils;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
    } mem_res_t;

endpackage

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache with one 32-bit word
// per line. Tag and data arrays are block RAMs with a registered (1-cycle) read; line-valid
// bits live in flops so that reset and flush can clear them in a single cycle.
//
// Optional feature: define DCACHE_STATS_EN to build the read hit/miss counters. Without it,
// hit_count and miss_count are tied to zero and no counter flops exist.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   core_req   : core request {valid, rw, addr, data}
//   core_res   : core response {ready pulse, data}
//   mem_req    : request to the memory controller, held stable while valid
//   mem_res    : memory response {ready pulse, data}
//   flush      : invalidate all lines (honoured in IDLE only)
//   busy       : high whenever the FSM is not in IDLE
//   hit_count  : read-hit counter
//   miss_count : read-miss counter
module dcache_dm #(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  utils::mem_req_t   core_req,
    output utils::mem_res_t   core_res,
    output utils::mem_req_t   mem_req,
    input  utils::mem_res_t   mem_res,
    input  logic              flush,
    output logic              busy,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned Lines   = 2 ** INDEX_BITS;
    localparam int unsigned TagBits = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {StIdle, StLookup, StMemWait, StDone} state_e;

    state_e state_q, state_d;

    // Latched core request; not reset, only meaningful after a request is taken.
    utils::mem_req_t req_q;

    logic [TagBits-1:0]    tag_mem  [Lines];
    logic [31:0]           data_mem [Lines];
    logic [TagBits-1:0]    tag_rd_q;
    logic [31:0]           data_rd_q;
    logic [Lines-1:0]      valid_q, valid_d;

    logic                  core_ready_q, core_ready_d;
    logic [31:0]           core_data_q, core_data_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_data_q, mem_data_d;

    logic                  arr_we;
    logic [31:0]           arr_wdata;
    logic                  hit_inc, miss_inc;

    logic [INDEX_BITS-1:0] req_idx, core_idx;
    logic [TagBits-1:0]    req_tag;
    logic                  hit;
    logic                  take_req;

    assign req_idx  = req_q.addr[INDEX_BITS+1:2];
    assign req_tag  = req_q.addr[31:INDEX_BITS+2];
    assign core_idx = core_req.addr[INDEX_BITS+1:2];
    assign hit      = valid_q[req_idx] && (tag_rd_q == req_tag);
    assign take_req = (state_q == StIdle) && core_req.valid && !flush;

    // ------------------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_req) state_d = StLookup;
            end
            StLookup: begin
                if (!req_q.rw && hit) state_d = StDone;
                else                  state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_res.ready) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------------------------
    always_comb begin
        core_ready_d = 1'b0;
        core_data_d  = core_data_q;
        mem_valid_d  = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        valid_d      = valid_q;
        arr_we       = 1'b0;
        arr_wdata    = req_q.data;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush) valid_d = '0;
            end
            StLookup: begin
                if (req_q.rw) begin
                    // Write-through: always forward; refresh the line only when it is present.
                    mem_valid_d = 1'b1;
                    mem_rw_d    = 1'b1;
                    mem_addr_d  = req_q.addr;
                    mem_data_d  = req_q.data;
                    arr_we      = hit;
                end else if (hit) begin
                    core_ready_d = 1'b1;
                    core_data_d  = data_rd_q;
                    hit_inc      = 1'b1;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = req_q.addr;
                    mem_data_d  = req_q.data;
                    miss_inc    = 1'b1;
                end
            end
            StMemWait: begin
                mem_valid_d = 1'b1;
                if (mem_res.ready) begin
                    mem_valid_d  = 1'b0;
                    core_ready_d = 1'b1;
                    if (!req_q.rw) begin
                        core_data_d      = mem_res.data;
                        arr_we           = 1'b1;
                        arr_wdata        = mem_res.data;
                        valid_d[req_idx] = 1'b1;
                    end
                end
            end
            StDone: begin
                core_ready_d = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------------------
    // Control flops (reset)
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            core_ready_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            valid_q      <= '0;
        end else begin
            core_ready_q <= core_ready_d;
            mem_valid_q  <= mem_valid_d;
            valid_q      <= valid_d;
        end
    end

    // Data flops (no reset)
    always_ff @(posedge clk) begin
        if (take_req) req_q <= core_req;
        core_data_q <= core_data_d;
        mem_rw_q    <= mem_rw_d;
        mem_addr_q  <= mem_addr_d;
        mem_data_q  <= mem_data_d;
    end

    // Tag/data block RAM: one write port, registered read addressed by the incoming request
    // while idle so the line is ready when LOOKUP starts.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= arr_wdata;
        end
        if (state_q == StIdle) begin
            tag_rd_q  <= tag_mem[core_idx];
            data_rd_q <= data_mem[core_idx];
        end
    end

    // ------------------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------------------
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_inc ^ miss_inc;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

    logic unused_req_valid;
    assign unused_req_valid = req_q.valid;

    assign busy          = (state_q != StIdle);
    assign core_res.ready = core_ready_q;
    assign core_res.data  = core_data_q;
    assign mem_req.valid  = mem_valid_q;
    assign mem_req.rw     = mem_rw_q;
    assign mem_req.addr   = mem_addr_q;
    assign mem_req.data   = mem_data_q;

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed self-checking bench for dcache_dm (INDEX_BITS = 8). A small
// memory responder answers each memory request two cycles after it appears. Statistics
// expectations follow DCACHE_STATS_EN: counted values when defined, zero otherwise.
module tb_dcache_dm;

    logic            clk;
    logic            rst;
    utils::mem_req_t core_req;
    utils::mem_res_t core_res;
    utils::mem_req_t mem_req;
    utils::mem_res_t mem_res;
    logic            flush;
    logic            busy;
    logic [31:0]     hit_count;
    logic [31:0]     miss_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    dcache_dm #(.INDEX_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_res   (core_res),
        .mem_req    (mem_req),
        .mem_res    (mem_res),
        .flush      (flush),
        .busy       (busy),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bump the expected statistics; they stay zero when the counters are not built.
    task automatic note_read(input logic was_hit);
`ifdef DCACHE_STATS_EN
        if (was_hit) exp_hit++;
        else         exp_miss++;
`else
        if (was_hit) exp_hit = 0;
`endif
    endtask

    // Presents one request for a single cycle, then watches a fixed 15-cycle window,
    // acting as memory and recording what the DUT did.
    task automatic transact(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] memdata,
                            output int n_rd, output int n_wr, output int n_rdy,
                            output int rdy_cyc, output int n_unst,
                            output logic [31:0] rdata, output logic [31:0] maddr,
                            output logic [31:0] mwdata);
        logic        seen;
        int          wcnt;
        logic [64:0] snap;
        n_rd = 0; n_wr = 0; n_rdy = 0; rdy_cyc = 0; n_unst = 0;
        rdata = '0; maddr = '0; mwdata = '0;
        seen = 1'b0; wcnt = 0; snap = '0;
        @(negedge clk);
        core_req = '{valid: 1'b1, rw: rw, addr: addr, data: wdata};
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            core_req.valid = 1'b0;
            mem_res.ready  = 1'b0;
            if (core_res.ready) begin
                n_rdy++;
                if (rdy_cyc == 0) rdy_cyc = c;
                rdata = core_res.data;
            end
            if (mem_req.valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    wcnt = 0;
                    snap = {mem_req.rw, mem_req.addr, mem_req.data};
                    if (mem_req.rw) n_wr++;
                    else            n_rd++;
                    maddr  = mem_req.addr;
                    mwdata = mem_req.data;
                end else if (snap !== {mem_req.rw, mem_req.addr, mem_req.data}) begin
                    n_unst++;
                end
                wcnt++;
                if (wcnt == 2) begin
                    mem_res.ready = 1'b1;
                    mem_res.data  = memdata;
                end
            end else begin
                seen = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (core_res.ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_core_ready: got %b expected 0", core_res.ready);
        end
        n_checks++;
        if (mem_req.valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_valid: got %b expected 0", mem_req.valid);
        end
        n_checks++;
        if (hit_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count);
        end
        n_checks++;
        if (miss_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_miss_count: got %0d expected 0", miss_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        int n_rd, n_wr, n_rdy, rdy_cyc, n_unst;
        logic [31:0] rdata, maddr, mwdata;
        transact(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        note_read(1'b0);
        n_checks++;
        if (n_rd !== 1 || n_wr !== 0) begin
            n_fail++; $display("FAIL miss_mem_ops: got rd=%0d wr=%0d expected rd=1 wr=0", n_rd, n_wr);
        end
        n_checks++;
        if (maddr !== 32'h100) begin
            n_fail++; $display("FAIL miss_mem_addr: got %h expected 00000100", maddr);
        end
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL miss_data: got %h expected deadbeef", rdata);
        end
        n_checks++;
        if (n_rdy !== 1) begin
            n_fail++; $display("FAIL miss_ready_pulses: got %0d expected 1", n_rdy);
        end
        n_checks++;
        if (n_unst !== 0) begin
            n_fail++; $display("FAIL miss_mem_stable: got %0d changes expected 0", n_unst);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL miss_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_read_hit();
        int n_rd, n_wr, n_rdy, rdy_cyc, n_unst;
        logic [31:0] rdata, maddr, mwdata;
        transact(1'b0, 32'h0000_0100, 32'h0, 32'h0000_0BAD,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        note_read(1'b1);
        n_checks++;
        if (n_rd + n_wr !== 0) begin
            n_fail++; $display("FAIL hit_mem_ops: got %0d expected 0", n_rd + n_wr);
        end
        n_checks++;
        if (rdy_cyc !== 2) begin
            n_fail++; $display("FAIL hit_latency: got %0d expected 2", rdy_cyc);
        end
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL hit_data: got %h expected deadbeef", rdata);
        end
        n_checks++;
        if (n_rdy !== 1) begin
            n_fail++; $display("FAIL hit_ready_pulses: got %0d expected 1", n_rdy);
        end
        n_checks++;
        if (hit_count !== 32'(exp_hit) || miss_count !== 32'(exp_miss)) begin
            n_fail++;
            $display("FAIL hit_stats: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     hit_count, miss_count, exp_hit, exp_miss);
        end
    endtask

    task automatic test_write();
        int n_rd, n_wr, n_rdy, rdy_cyc, n_unst;
        logic [31:0] rdata, maddr, mwdata;
        // Write hit: forwarded to memory and the line is refreshed.
        transact(1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        n_checks++;
        if (n_wr !== 1 || n_rd !== 0) begin
            n_fail++; $display("FAIL wr_mem_ops: got rd=%0d wr=%0d expected rd=0 wr=1", n_rd, n_wr);
        end
        n_checks++;
        if (maddr !== 32'h100 || mwdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wr_mem_fields: got addr=%h data=%h expected 00000100 12345678",
                     maddr, mwdata);
        end
        n_checks++;
        if (n_rdy !== 1 || n_unst !== 0) begin
            n_fail++; $display("FAIL wr_handshake: got pulses=%0d changes=%0d expected 1 0",
                               n_rdy, n_unst);
        end
        transact(1'b0, 32'h0000_0100, 32'h0, 32'h0000_0BAD,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        note_read(1'b1);
        n_checks++;
        if (n_rd + n_wr !== 0 || rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL wr_readback: got ops=%0d data=%h expected 0 12345678",
                               n_rd + n_wr, rdata);
        end
        // Write miss: memory is written but no line is allocated.
        transact(1'b1, 32'h0000_03F0, 32'hAAAA_5555, 32'h0,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        n_checks++;
        if (n_wr !== 1 || mwdata !== 32'hAAAA_5555) begin
            n_fail++; $display("FAIL wrmiss_mem: got wr=%0d data=%h expected 1 aaaa5555", n_wr, mwdata);
        end
        transact(1'b0, 32'h0000_03F0, 32'h0, 32'h0F0F_0F0F,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        note_read(1'b0);
        n_checks++;
        if (n_rd !== 1 || rdata !== 32'h0F0F_0F0F) begin
            n_fail++; $display("FAIL wrmiss_no_alloc: got rd=%0d data=%h expected 1 0f0f0f0f",
                               n_rd, rdata);
        end
    endtask

    task automatic test_flush();
        int n_rd, n_wr, n_rdy, rdy_cyc, n_unst;
        logic [31:0] rdata, maddr, mwdata;
        @(negedge clk);
        flush    = 1'b1;
        core_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0100, data: 32'h0};
        @(negedge clk);
        flush          = 1'b0;
        core_req.valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_priority: got busy=%b expected 0", busy);
        end
        transact(1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        note_read(1'b0);
        n_checks++;
        if (n_rd !== 1 || maddr !== 32'h100 || rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL flush_refetch: got rd=%0d addr=%h data=%h expected 1 00000100 cafef00d",
                               n_rd, maddr, rdata);
        end
    endtask

    task automatic test_conflict();
        int n_rd, n_wr, n_rdy, rdy_cyc, n_unst;
        int total_rd;
        logic [31:0] rdata, maddr, mwdata;
        total_rd = 0;
        transact(1'b0, 32'h0000_0108, 32'h0, 32'h1111_1111,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        total_rd += n_rd;
        note_read(1'b0);
        transact(1'b0, 32'h0000_0508, 32'h0, 32'h2222_2222,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        total_rd += n_rd;
        note_read(1'b0);
        n_checks++;
        if (rdata !== 32'h2222_2222) begin
            n_fail++; $display("FAIL conflict_second: got %h expected 22222222", rdata);
        end
        transact(1'b0, 32'h0000_0108, 32'h0, 32'h3333_3333,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        total_rd += n_rd;
        note_read(1'b0);
        n_checks++;
        if (total_rd !== 3 || rdata !== 32'h3333_3333) begin
            n_fail++; $display("FAIL conflict_reads: got reads=%0d data=%h expected 3 33333333",
                               total_rd, rdata);
        end
        n_checks++;
        if (hit_count !== 32'(exp_hit) || miss_count !== 32'(exp_miss)) begin
            n_fail++;
            $display("FAIL conflict_stats: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     hit_count, miss_count, exp_hit, exp_miss);
        end
    endtask

    task automatic test_reset_in_mem_wait();
        int n_rd, n_wr, n_rdy, rdy_cyc, n_unst;
        int rdy, bsy, mv;
        logic got;
        logic [31:0] rdata, maddr, mwdata;
        @(negedge clk);
        core_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0200, data: 32'h0};
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            core_req.valid = 1'b0;
            if (mem_req.valid) got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++; $display("FAIL rstwait_mem_req: got %b expected 1", got);
        end
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        mem_res.ready = 1'b1;
        mem_res.data  = 32'h0000_0055;
        rdy = 0; bsy = 0; mv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_res.ready = 1'b0;
            if (core_res.ready) rdy++;
            if (busy) bsy++;
            if (mem_req.valid) mv++;
        end
        n_checks++;
        if (rdy !== 0 || bsy !== 0 || mv !== 0) begin
            n_fail++; $display("FAIL rstwait_quiet: got ready=%0d busy=%0d memvalid=%0d expected 0 0 0",
                               rdy, bsy, mv);
        end
        exp_hit  = 0;
        exp_miss = 0;
        transact(1'b0, 32'h0000_0200, 32'h0, 32'h7777_7777,
                 n_rd, n_wr, n_rdy, rdy_cyc, n_unst, rdata, maddr, mwdata);
        note_read(1'b0);
        n_checks++;
        if (n_rd !== 1 || rdata !== 32'h7777_7777) begin
            n_fail++; $display("FAIL rstwait_remiss: got rd=%0d data=%h expected 1 77777777",
                               n_rd, rdata);
        end
        n_checks++;
        if (hit_count !== 32'(exp_hit) || miss_count !== 32'(exp_miss)) begin
            n_fail++;
            $display("FAIL rstwait_stats: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     hit_count, miss_count, exp_hit, exp_miss);
        end
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        core_req = '0;
        mem_res  = '0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_flush();
        test_conflict();
        test_reset_in_mem_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
